ps2_key_port: RTL and testbench

PS2_KEY_PORT -- requirements
Module: ps2_key_port

---
 rtl/ps2_key_port.sv | 195 +++++++++++++++++++
 tb/tb_ps2_key_port.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ps2_key_port.sv
// PS/2 keyboard receiver with make-code filter, small FIFO and PicoBlaze read port.
// Port 0x0A pops scan codes; port 0x0B returns {ovf, perr, full, not-empty} and clears the sticky flags.
module ps2_key_port #(
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic [7:0] port_ID,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       key_ready
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRx, StDone} state_e;

    logic             ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
    logic [7:0]       filt_reg;
    logic             filt_q;
    logic             bit_evt;

    state_e           state_q, state_d;
    logic [9:0]       sr_q, sr_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic             frame_ok, frame_bad;
    logic [7:0]       rx_byte;
    logic             brk_q, brk_d;
    logic             push_q, push_d;
    logic [7:0]       push_data_q;

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW-1:0] rptr_q, wptr_q;
    logic [FIFO_AW:0] count_q;
    logic             empty, full, pop, wr;
    logic             stat_rd;
    logic             perr_q, ovf_q;
    logic [7:0]       in_port_d;

    // Synchronizers and glitch filter on the PS/2 clock
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_s1  <= 1'b1;
            ps2c_s2  <= 1'b1;
            ps2d_s1  <= 1'b1;
            ps2d_s2  <= 1'b1;
            filt_reg <= 8'hFF;
            filt_q   <= 1'b1;
        end else begin
            ps2c_s1  <= ps2c;
            ps2c_s2  <= ps2c_s1;
            ps2d_s1  <= ps2d;
            ps2d_s2  <= ps2d_s1;
            filt_reg <= {filt_reg[6:0], ps2c_s2};
            if (filt_reg == 8'h00) begin
                filt_q <= 1'b0;
            end else if (filt_reg == 8'hFF) begin
                filt_q <= 1'b1;
            end
        end
    end

    assign bit_evt = filt_q & (filt_reg == 8'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sr_q    <= '0;
            bcnt_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcnt_d  = bcnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            StIdle: begin
                if (bit_evt && !ps2d_s2) begin
                    state_d = StRx;
                    bcnt_d  = '0;
                    tmo_d   = '0;
                end
            end
            StRx: begin
                if (bit_evt) begin
                    sr_d  = {ps2d_s2, sr_q[9:1]};
                    tmo_d = '0;
                    if (bcnt_q == 4'd9) begin
                        state_d = StDone;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // sr_q holds {stop, parity, data[7:0]} once the tenth bit is shifted in
    assign rx_byte   = sr_q[7:0];
    assign frame_ok  = (state_q == StDone) && (^sr_q[8:0]) && sr_q[9];
    assign frame_bad = (state_q == StDone) && !frame_ok;

    always_comb begin
        brk_d  = brk_q;
        push_d = 1'b0;
        if (frame_ok) begin
            if (rx_byte == 8'hF0) begin
                brk_d = 1'b1;
            end else if (rx_byte == 8'hE0) begin
                brk_d = brk_q;
            end else if (brk_q) begin
                brk_d = 1'b0;
            end else begin
                push_d = 1'b1;
            end
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign pop     = read_strobe && (port_ID == 8'h0A) && !empty;
    assign wr      = push_q && (!full || pop);
    assign stat_rd = read_strobe && (port_ID == 8'h0B);

    always_comb begin
        in_port_d = 8'h00;
        case (port_ID)
            8'h0A:   in_port_d = empty ? 8'h00 : mem_q[rptr_q];
            8'h0B:   in_port_d = {4'b0000, ovf_q, perr_q, full, ~empty};
            default: in_port_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wptr_q] <= push_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            perr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_port     <= 8'h00;
            key_ready   <= 1'b0;
        end else begin
            brk_q       <= brk_d;
            push_q      <= push_d;
            push_data_q <= rx_byte;
            if (wr) begin
                wptr_q <= wptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + FIFO_AW'(1);
            end
            if (wr && !pop) begin
                count_q <= count_q + (FIFO_AW + 1)'(1);
            end else if (pop && !wr) begin
                count_q <= count_q - (FIFO_AW + 1)'(1);
            end
            // Set events take priority over the read-to-clear
            perr_q    <= frame_bad | (perr_q & ~stat_rd);
            ovf_q     <= (push_q && full && !pop) | (ovf_q & ~stat_rd);
            in_port   <= in_port_d;
            key_ready <= ~empty;
        end
    end

endmodule

// File: tb/tb_ps2_key_port.sv
// Directed bench for ps2_key_port: bit-banged PS/2 frames and PicoBlaze-style port reads.
module tb_ps2_key_port;

    localparam int H = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c, ps2d;
    logic [7:0] port_ID;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       key_ready;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic       kr_probe;
    logic [7:0] rd;

    ps2_key_port #(.FIFO_AW(2), .TIMEOUT(200)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .port_ID     (port_ID),
        .read_strobe (read_strobe),
        .in_port     (in_port),
        .key_ready   (key_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // probe samples key_ready 14 clk after the falling PS/2 clock:
    // 2 sync + 8 filter samples + 1 to register the edge, then 3 allowed
    task automatic send_bit(input logic b, input bit probe);
        @(negedge clk) ps2d = b;
        repeat (H) @(negedge clk);
        ps2c = 1'b0;
        if (probe) begin
            repeat (14) @(posedge clk);
            #1 kr_probe = key_ready;
            repeat (H - 14) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit good_par);
        logic par;
        par = ~^data;
        if (!good_par) par = ~par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i], 1'b0);
        send_bit(par, 1'b0);
        send_bit(1'b1, 1'b1);
        repeat (H) @(negedge clk);
    endtask

    task automatic read_port(input logic [7:0] id, output logic [7:0] val);
        @(negedge clk);
        port_ID     = id;
        read_strobe = 1'b1;
        @(posedge clk);
        #1 val = in_port;
        @(negedge clk);
        read_strobe = 1'b0;
        port_ID     = 8'h00;
    endtask

    initial begin
        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; port_ID = 8'h00; read_strobe = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        chk("reset_in_port", in_port, 8'h00);
        chk("reset_key_ready", {7'b0, key_ready}, 8'h00);
        read_port(8'h0B, rd); chk("reset_status", rd, 8'h00);

        // single good frame
        send_frame(8'h1C, 1'b1);
        chk("ready_within_3", {7'b0, kr_probe}, 8'h01);
        read_port(8'h0A, rd); chk("pop_1c", rd, 8'h1C);
        @(posedge clk); #1;
        chk("ready_low_after_pop", {7'b0, key_ready}, 8'h00);

        // extended and break codes filtered
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        send_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h75, 1'b1);
        read_port(8'h0A, rd); chk("filter_pop_75", rd, 8'h75);
        read_port(8'h0B, rd); chk("filter_one_entry", rd, 8'h00);
        send_frame(8'h1C, 1'b1);
        read_port(8'h0A, rd); chk("brk_cleared", rd, 8'h1C);

        // parity error
        send_frame(8'h1C, 1'b0);
        chk("perr_no_ready", {7'b0, key_ready}, 8'h00);
        read_port(8'h0B, rd); chk("perr_status", rd, 8'h04);
        read_port(8'h0B, rd); chk("perr_cleared", rd, 8'h00);

        // overflow
        send_frame(8'h16, 1'b1);
        send_frame(8'h1E, 1'b1);
        send_frame(8'h26, 1'b1);
        send_frame(8'h25, 1'b1);
        send_frame(8'h2E, 1'b1);
        read_port(8'h0B, rd); chk("ovf_status", rd, 8'h0B);
        read_port(8'h0A, rd); chk("ovf_pop0", rd, 8'h16);
        read_port(8'h0A, rd); chk("ovf_pop1", rd, 8'h1E);
        read_port(8'h0A, rd); chk("ovf_pop2", rd, 8'h26);
        read_port(8'h0A, rd); chk("ovf_pop3", rd, 8'h25);
        read_port(8'h0A, rd); chk("ovf_pop_empty", rd, 8'h00);
        read_port(8'h0B, rd); chk("ovf_cleared", rd, 8'h00);

        // partial frame abandoned on timeout
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        repeat (400) @(negedge clk);
        send_frame(8'h1C, 1'b1);
        read_port(8'h0B, rd); chk("tmo_status", rd, 8'h01);
        read_port(8'h0A, rd); chk("tmo_pop", rd, 8'h1C);
        read_port(8'h0B, rd); chk("tmo_empty", rd, 8'h00);

        // reset mid-frame
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (H) @(negedge clk);
        chk("rst_mid_ready", {7'b0, key_ready}, 8'h00);
        read_port(8'h0B, rd); chk("rst_mid_status", rd, 8'h00);
        send_frame(8'h2E, 1'b1);
        read_port(8'h0A, rd); chk("rst_mid_next", rd, 8'h2E);
        read_port(8'h0B, rd); chk("rst_mid_final", rd, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
